// File: rtl/tank_pump_ctrl.sv
// Fill controller for the five-probe water tank: probe debounce, level/LED
// decode, hysteretic pump sequencing, and latched fault reporting.
// Latency: probe change to level/led is DEB_CYCLES+1 cycles. The FSM and pump react one cycle later.
module tank_pump_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int LOW_LVL      = 1,
  parameter int RISE_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] probe,
  input  logic       clr_fault,
  output logic       pump_on,
  output logic [2:0] level,
  output logic [4:0] led,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int             DCW      = $clog2(DEB_CYCLES + 1);
  localparam int             TCW      = $clog2(RISE_TIMEOUT + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(RISE_TIMEOUT - 1);
  localparam logic [2:0]     LOW_THR  = 3'(LOW_LVL);
  localparam logic [2:0]     LVL_TOP  = 3'd5;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_PATTERN = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // A probe pattern is legal only when the wet probes form a contiguous run
  // from the bottom. This holds exactly when p+1 shares no set bit with p.
  function automatic logic is_therm(input logic [4:0] p);
    return ((p & (p + 5'd1)) == 5'd0);
  endfunction

  function automatic logic [2:0] popcnt(input logic [4:0] p);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, p[i]};
    return n;
  endfunction

  logic [4:0]     raw_q;
  logic [DCW-1:0] deb_cnt_q;
  logic           stab_ok_q;   // last accepted pattern was a legal thermometer code
  logic           stab_bad_q;  // last accepted pattern was illegal
  logic [2:0]     level_q;
  logic [4:0]     led_q;       // a legal stable pattern is already the LED image

  logic           deb_hit;
  logic           raw_therm;

  assign deb_hit   = (deb_cnt_q == DEB_LAST);
  assign raw_therm = is_therm(raw_q);

  // Debounce: accept raw_q once it has matched probe for DEB_CYCLES samples.
  // Until the first pattern is accepted after reset neither flag is set, so
  // the pump cannot start on the reset value of level.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q      <= 5'd0;
      deb_cnt_q  <= '0;
      stab_ok_q  <= 1'b0;
      stab_bad_q <= 1'b0;
      level_q    <= 3'd0;
      led_q      <= 5'd0;
    end else begin
      raw_q <= probe;
      if (probe != raw_q)
        deb_cnt_q <= '0;
      else if (!deb_hit)
        deb_cnt_q <= deb_cnt_q + DCW'(1);

      if (deb_hit) begin
        if (raw_therm) begin
          stab_ok_q  <= 1'b1;
          stab_bad_q <= 1'b0;
          level_q    <= popcnt(raw_q);
          led_q      <= raw_q;
        end else begin
          // Level and LEDs keep their last legal values.
          stab_ok_q  <= 1'b0;
          stab_bad_q <= 1'b1;
        end
      end
    end
  end

  state_t         state_q;
  logic           pump_q;
  logic           fault_q;
  logic [1:0]     code_q;
  logic [TCW-1:0] tmo_q;
  logic [2:0]     lvl_prev_q;
  logic           lvl_up;

  assign lvl_up = (level_q > lvl_prev_q);

  // Pump sequencing FSM with registered outputs. Pattern faults outrank
  // everything. In FILL, reaching the top outranks the rise timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pump_q     <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= CODE_NONE;
      tmo_q      <= '0;
      lvl_prev_q <= 3'd0;
    end else begin
      lvl_prev_q <= level_q;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (stab_bad_q) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            code_q  <= CODE_PATTERN;
          end else if (stab_ok_q && (level_q <= LOW_THR)) begin
            state_q <= FILL;
            pump_q  <= 1'b1;
          end
        end
        FILL: begin
          if (stab_bad_q) begin
            state_q <= FAULT;
            pump_q  <= 1'b0;
            fault_q <= 1'b1;
            code_q  <= CODE_PATTERN;
            tmo_q   <= '0;
          end else if (level_q == LVL_TOP) begin
            state_q <= FULL;
            pump_q  <= 1'b0;
            tmo_q   <= '0;
          end else if (lvl_up) begin
            tmo_q <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= FAULT;
            pump_q  <= 1'b0;
            fault_q <= 1'b1;
            code_q  <= CODE_TIMEOUT;
            tmo_q   <= '0;
          end else begin
            // Draw-off (level falling) keeps counting. The counter never passes TMO_LAST.
            tmo_q <= tmo_q + TCW'(1);
          end
        end
        FULL: begin
          tmo_q <= '0;
          if (stab_bad_q) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            code_q  <= CODE_PATTERN;
          end else if (level_q < LVL_TOP) begin
            // Hysteresis: the pump restarts only via the IDLE threshold.
            state_q <= IDLE;
          end
        end
        default: begin
          // FAULT: hold the code until the operator clears it with a legal pattern present.
          tmo_q <= '0;
          if (clr_fault && stab_ok_q) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            code_q  <= CODE_NONE;
          end
        end
      endcase
    end
  end

  assign pump_on    = pump_q;
  assign level      = level_q;
  assign led        = led_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_tank_pump_ctrl.sv
// Directed bench for tank_pump_ctrl: scoreboard of expected output vectors,
// checked with immediate assertions at fixed sample points (#1 after posedge).
module tb_tank_pump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] probe;
  logic       clr_fault;
  logic       pump_on;
  logic [2:0] level;
  logic [4:0] led;
  logic       fault;
  logic [1:0] fault_code;

  int tests = 0;
  int fails = 0;
  int n;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  tank_pump_ctrl #(
    .DEB_CYCLES  (4),
    .LOW_LVL     (1),
    .RISE_TIMEOUT(1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .probe     (probe),
    .clr_fault (clr_fault),
    .pump_on   (pump_on),
    .level     (level),
    .led       (led),
    .fault     (fault),
    .fault_code(fault_code)
  );

  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic p, input logic [2:0] l,
                      input logic [4:0] ld, input logic f, input logic [1:0] c);
    exp_t e;
    e.tag = tag;
    e.v   = {p, l, ld, f, c};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, 32'({pump_on, level, led, fault, fault_code}), 32'(e.v));
  endtask

  // Push the expected {pump_on, level, led, fault, fault_code} vector, advance cnt cycles, then compare.
  task automatic expect_after(input int cnt, input string tag, input logic p,
                              input logic [2:0] l, input logic [4:0] ld,
                              input logic f, input logic [1:0] c);
    push(tag, p, l, ld, f, c);
    tick(cnt);
    pop_check();
  endtask

  task automatic wait_pump(output int cnt);
    cnt = 0;
    while (pump_on !== 1'b1 && cnt < 50) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic count_to_fault(output int cnt);
    cnt = 0;
    while (fault !== 1'b1 && cnt < 1500) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    // 1. Reset and hold
    rst = 1'b1; probe = 5'b00111; clr_fault = 1'b0;
    tick(2);
    expect_after(0, "reset_state", 1'b0, 3'd0, 5'b00000, 1'b0, 2'b00);
    rst = 1'b0;
    expect_after(4, "deb_not_yet", 1'b0, 3'd0, 5'b00000, 1'b0, 2'b00);
    expect_after(1, "deb_accept_l3", 1'b0, 3'd3, 5'b00111, 1'b0, 2'b00);
    expect_after(3, "idle_above_low", 1'b0, 3'd3, 5'b00111, 1'b0, 2'b00);

    // 2. Fill cycle with hysteresis
    probe = 5'b00001;
    expect_after(5, "lvl1_pump_off", 1'b0, 3'd1, 5'b00001, 1'b0, 2'b00);
    expect_after(1, "pump_start", 1'b1, 3'd1, 5'b00001, 1'b0, 2'b00);
    probe = 5'b00011;
    expect_after(300, "fill_l2", 1'b1, 3'd2, 5'b00011, 1'b0, 2'b00);
    probe = 5'b00111;
    expect_after(300, "fill_l3", 1'b1, 3'd3, 5'b00111, 1'b0, 2'b00);
    probe = 5'b01111;
    expect_after(300, "fill_l4", 1'b1, 3'd4, 5'b01111, 1'b0, 2'b00);
    probe = 5'b11111;
    expect_after(5, "l5_pump_still_on", 1'b1, 3'd5, 5'b11111, 1'b0, 2'b00);
    expect_after(1, "full_stop", 1'b0, 3'd5, 5'b11111, 1'b0, 2'b00);
    probe = 5'b01111;
    expect_after(20, "full_to_idle", 1'b0, 3'd4, 5'b01111, 1'b0, 2'b00);
    probe = 5'b00011;
    expect_after(20, "hyst_l2_off", 1'b0, 3'd2, 5'b00011, 1'b0, 2'b00);
    probe = 5'b00001;
    expect_after(5, "l1_before_start", 1'b0, 3'd1, 5'b00001, 1'b0, 2'b00);
    expect_after(1, "restart", 1'b1, 3'd1, 5'b00001, 1'b0, 2'b00);

    // 3. Debounce glitch, plus drain during FILL
    probe = 5'b00000;
    expect_after(6, "drain_l0", 1'b1, 3'd0, 5'b00000, 1'b0, 2'b00);
    probe = 5'b00001;
    tick(3);
    probe = 5'b00000;
    expect_after(10, "glitch_reject", 1'b1, 3'd0, 5'b00000, 1'b0, 2'b00);
    clr_fault = 1'b1;
    expect_after(1, "clr_in_fill", 1'b1, 3'd0, 5'b00000, 1'b0, 2'b00);
    clr_fault = 1'b0;

    // 4. Dry run timeout
    rst = 1'b1; probe = 5'b00000;
    expect_after(1, "rst_before_dry", 1'b0, 3'd0, 5'b00000, 1'b0, 2'b00);
    rst = 1'b0;
    wait_pump(n);
    chk("dry_pump_on", 32'(pump_on), 32'd1);
    count_to_fault(n);
    chk("dry_run_cycles", n, 32'd1000);
    expect_after(0, "dry_fault", 1'b0, 3'd0, 5'b00000, 1'b1, 2'b10);
    clr_fault = 1'b1;
    expect_after(1, "clr_timeout", 1'b0, 3'd0, 5'b00000, 1'b0, 2'b00);
    clr_fault = 1'b0;
    expect_after(1, "refill", 1'b1, 3'd0, 5'b00000, 1'b0, 2'b00);

    // 5. Bad pattern
    probe = 5'b00011;
    expect_after(6, "t5_l2", 1'b1, 3'd2, 5'b00011, 1'b0, 2'b00);
    probe = 5'b00101;
    expect_after(5, "bad_accepted", 1'b1, 3'd2, 5'b00011, 1'b0, 2'b00);
    expect_after(1, "bad_fault", 1'b0, 3'd2, 5'b00011, 1'b1, 2'b01);
    clr_fault = 1'b1;
    expect_after(1, "clr_bad_ignored", 1'b0, 3'd2, 5'b00011, 1'b1, 2'b01);
    clr_fault = 1'b0;
    probe = 5'b00111;
    expect_after(6, "restored_in_fault", 1'b0, 3'd3, 5'b00111, 1'b1, 2'b01);
    clr_fault = 1'b1;
    expect_after(1, "clr_pattern", 1'b0, 3'd3, 5'b00111, 1'b0, 2'b00);
    clr_fault = 1'b0;
    tick(1);
    clr_fault = 1'b1;
    expect_after(1, "clr_idle_ignored", 1'b0, 3'd3, 5'b00111, 1'b0, 2'b00);
    clr_fault = 1'b0;
    expect_after(3, "idle_hold", 1'b0, 3'd3, 5'b00111, 1'b0, 2'b00);

    // 6. Reset mid-fill
    probe = 5'b00000;
    wait_pump(n);
    chk("t6_pump_on", 32'(pump_on), 32'd1);
    tick(500);
    expect_after(0, "mid_fill", 1'b1, 3'd0, 5'b00000, 1'b0, 2'b00);
    rst = 1'b1;
    expect_after(1, "rst_mid_fill", 1'b0, 3'd0, 5'b00000, 1'b0, 2'b00);
    rst = 1'b0;
    wait_pump(n);
    chk("t6_refill", 32'(pump_on), 32'd1);
    count_to_fault(n);
    chk("tmo_restart_cycles", n, 32'd1000);
    expect_after(0, "t6_fault", 1'b0, 3'd0, 5'b00000, 1'b1, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
